// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle MIPS-subset datapath. Each instruction walks
//   FETCH -> DECODE -> execute/memory/writeback states and returns to FETCH.
//   The controls decode from the registered state. Only the BRANCH, REXEC and
//   IEXEC controls, and the illegal flag in DECODE, also look at opcode/func.
//
// Configuration macro:
//   MC_JAL_JR_EN - when defined, adds the JAL (opcode 3) and JR (R-type func 8)
//                  states; when undefined both encodings decode as illegal
//                  and link is tied to 0.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset; forces every output to 0
//   opcode[5:0]    in   IR[31:26]
//   func[5:0]      in   IR[5:0]
//   AluOperation   out  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   PCSrc          out  00 ALU, 01 ALUOut, 10 jump target, 11 register A
//   AluSrcB        out  00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   AluSrcA, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
//   link, PCWrite, PCWriteCond, branch   out  datapath controls
//   illegal        out  one-cycle pulse on an unsupported instruction
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] AluOperation,
  output logic [1:0] PCSrc,
  output logic [1:0] AluSrcB,
  output logic       AluSrcA,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       link,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       branch,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB   = 4'd7,
    IEXEC  = 4'd8,  IWB    = 4'd9,  BRANCH = 4'd10, JUMP  = 4'd11
`ifdef MC_JAL_JR_EN
    , JAL  = 4'd12, JR     = 4'd13
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE  = 6'd5,  OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10, OP_LW   = 6'd35, OP_SW  = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8,  FN_ADD  = 6'd32, FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36, FN_OR   = 6'd37, FN_SLT = 6'd42;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  // ALU operation for an R-type func; unsupported funcs give 000
  function automatic logic [2:0] rAluOp(input logic [5:0] f);
    case (f)
      FN_ADD:  rAluOp = ALU_ADD;
      FN_SUB:  rAluOp = ALU_SUB;
      FN_AND:  rAluOp = ALU_AND;
      FN_OR:   rAluOp = ALU_OR;
      FN_SLT:  rAluOp = ALU_SLT;
      default: rAluOp = 3'b000;
    endcase
  endfunction

  // True for funcs that REXEC can execute (JR never reaches REXEC when enabled)
  function automatic logic rFuncLegal(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: rFuncLegal = 1'b1;
      default:                               rFuncLegal = 1'b0;
    endcase
  endfunction

  // True for opcodes DECODE dispatches somewhere other than back to FETCH
  function automatic logic opLegal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: opLegal = 1'b1;
`ifdef MC_JAL_JR_EN
      OP_JAL:  opLegal = 1'b1;
`endif
      default: opLegal = 1'b0;
    endcase
  endfunction

  state_t     stateR;
  logic [2:0] aluOpS;
  logic [1:0] pcSrcS, aluSrcBS;
  logic       aluSrcAS, iorDS, irWriteS, memReadS, memWriteS, memToRegS;
  logic       regDstS, regWriteS, pcWriteS, pcWriteCondS, branchS, illegalS;
`ifdef MC_JAL_JR_EN
  logic       linkS;
`endif

  // State register and next-state dispatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= FETCH;
    end else begin
      case (stateR)
        FETCH:  stateR <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW:     stateR <= MEMADR;
`ifdef MC_JAL_JR_EN
            OP_RTYPE:         stateR <= (func == FN_JR) ? JR : REXEC;
            OP_JAL:           stateR <= JAL;
`else
            OP_RTYPE:         stateR <= REXEC;
`endif
            OP_ADDI, OP_SLTI: stateR <= IEXEC;
            OP_BEQ, OP_BNE:   stateR <= BRANCH;
            OP_J:             stateR <= JUMP;
            default:          stateR <= FETCH;
          endcase
        end
        MEMADR: stateR <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  stateR <= MEMWB;
        REXEC:  stateR <= rFuncLegal(func) ? RWB : FETCH;
        IEXEC:  stateR <= IWB;
        default: stateR <= FETCH;
      endcase
    end
  end

  // Moore output decode. The IR loads on the edge that enters DECODE, so the
  // opcode-dependent controls must follow the live IR rather than a copy
  // registered on that same edge.
  always_comb begin
    aluOpS = 3'b000; pcSrcS = 2'b00; aluSrcBS = 2'b00; aluSrcAS = 1'b0;
    iorDS = 1'b0; irWriteS = 1'b0; memReadS = 1'b0; memWriteS = 1'b0;
    memToRegS = 1'b0; regDstS = 1'b0; regWriteS = 1'b0; pcWriteS = 1'b0;
    pcWriteCondS = 1'b0; branchS = 1'b0; illegalS = 1'b0;
`ifdef MC_JAL_JR_EN
    linkS = 1'b0;
`endif
    case (stateR)
      FETCH: begin
        memReadS = 1'b1; irWriteS = 1'b1; aluSrcBS = 2'b01;
        aluOpS = ALU_ADD; pcWriteS = 1'b1;
      end
      DECODE: begin
        aluSrcBS = 2'b11; aluOpS = ALU_ADD; illegalS = ~opLegal(opcode);
      end
      MEMADR: begin aluSrcAS = 1'b1; aluSrcBS = 2'b10; aluOpS = ALU_ADD; end
      MEMRD:  begin iorDS = 1'b1; memReadS = 1'b1; end
      MEMWB:  begin memToRegS = 1'b1; regWriteS = 1'b1; end
      MEMWR:  begin iorDS = 1'b1; memWriteS = 1'b1; end
      REXEC: begin
        aluSrcAS = 1'b1; aluOpS = rAluOp(func); illegalS = ~rFuncLegal(func);
      end
      RWB:    begin regDstS = 1'b1; regWriteS = 1'b1; end
      IEXEC: begin
        aluSrcAS = 1'b1; aluSrcBS = 2'b10;
        aluOpS = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      IWB:    regWriteS = 1'b1;
      BRANCH: begin
        aluSrcAS = 1'b1; aluOpS = ALU_SUB; pcSrcS = 2'b01; pcWriteCondS = 1'b1;
        branchS = (opcode == OP_BEQ);
      end
      JUMP:   begin pcSrcS = 2'b10; pcWriteS = 1'b1; end
`ifdef MC_JAL_JR_EN
      JAL:    begin pcSrcS = 2'b10; pcWriteS = 1'b1; linkS = 1'b1; regWriteS = 1'b1; end
      JR:     begin pcSrcS = 2'b11; pcWriteS = 1'b1; end
`endif
      default: illegalS = 1'b0;
    endcase
  end

  // Reset gates every control low immediately, independent of the clock
  assign AluOperation = rst ? 3'b000 : aluOpS;
  assign PCSrc        = rst ? 2'b00  : pcSrcS;
  assign AluSrcB      = rst ? 2'b00  : aluSrcBS;
  assign AluSrcA      = ~rst & aluSrcAS;
  assign IorD         = ~rst & iorDS;
  assign IRWrite      = ~rst & irWriteS;
  assign MemRead      = ~rst & memReadS;
  assign MemWrite     = ~rst & memWriteS;
  assign MemToReg     = ~rst & memToRegS;
  assign RegDst       = ~rst & regDstS;
  assign RegWrite     = ~rst & regWriteS;
  assign PCWrite      = ~rst & pcWriteS;
  assign PCWriteCond  = ~rst & pcWriteCondS;
  assign branch       = ~rst & branchS;
  assign illegal      = ~rst & illegalS;
`ifdef MC_JAL_JR_EN
  assign link         = ~rst & linkS;
`else
  assign link         = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller. Each cycle's full control
// word is compared against a hand-written constant. Packed order:
// {AluOperation, PCSrc, AluSrcB, AluSrcA, IorD, IRWrite, MemRead, MemWrite,
//  MemToReg, RegDst, RegWrite, link, PCWrite, PCWriteCond, branch, illegal}
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic [2:0] AluOperation;
  logic [1:0] PCSrc, AluSrcB;
  logic AluSrcA, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst;
  logic RegWrite, link, PCWrite, PCWriteCond, branch, illegal;

  int compared = 0;
  int mismatched = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .AluOperation(AluOperation), .PCSrc(PCSrc), .AluSrcB(AluSrcB),
    .AluSrcA(AluSrcA), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .link(link), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [19:0] obs = {AluOperation, PCSrc, AluSrcB, AluSrcA, IorD, IRWrite,
                     MemRead, MemWrite, MemToReg, RegDst, RegWrite, link,
                     PCWrite, PCWriteCond, branch, illegal};

  // singles: A IorD IRW MRd MWr M2R RDst RW link PCW PCWC br ill
  localparam logic [19:0] E_ZERO     = 20'd0;
  localparam logic [19:0] E_FETCH    = {3'b010, 2'b00, 2'b01, 13'b0011000001000};
  localparam logic [19:0] E_DECODE   = {3'b010, 2'b00, 2'b11, 13'b0000000000000};
  localparam logic [19:0] E_DEC_ILL  = {3'b010, 2'b00, 2'b11, 13'b0000000000001};
  localparam logic [19:0] E_MEMADR   = {3'b010, 2'b00, 2'b10, 13'b1000000000000};
  localparam logic [19:0] E_MEMRD    = {3'b000, 2'b00, 2'b00, 13'b0101000000000};
  localparam logic [19:0] E_MEMWB    = {3'b000, 2'b00, 2'b00, 13'b0000010100000};
  localparam logic [19:0] E_MEMWR    = {3'b000, 2'b00, 2'b00, 13'b0100100000000};
  localparam logic [19:0] E_REX_ADD  = {3'b010, 2'b00, 2'b00, 13'b1000000000000};
  localparam logic [19:0] E_REX_SUB  = {3'b110, 2'b00, 2'b00, 13'b1000000000000};
  localparam logic [19:0] E_REX_OR   = {3'b001, 2'b00, 2'b00, 13'b1000000000000};
  localparam logic [19:0] E_REX_SLT  = {3'b111, 2'b00, 2'b00, 13'b1000000000000};
  localparam logic [19:0] E_REX_ILL  = {3'b000, 2'b00, 2'b00, 13'b1000000000001};
  localparam logic [19:0] E_RWB      = {3'b000, 2'b00, 2'b00, 13'b0000001100000};
  localparam logic [19:0] E_IEX_ADD  = {3'b010, 2'b00, 2'b10, 13'b1000000000000};
  localparam logic [19:0] E_IEX_SLT  = {3'b111, 2'b00, 2'b10, 13'b1000000000000};
  localparam logic [19:0] E_IWB      = {3'b000, 2'b00, 2'b00, 13'b0000000100000};
  localparam logic [19:0] E_BEQ      = {3'b110, 2'b01, 2'b00, 13'b1000000000110};
  localparam logic [19:0] E_BNE      = {3'b110, 2'b01, 2'b00, 13'b1000000000100};
  localparam logic [19:0] E_JUMP     = {3'b000, 2'b10, 2'b00, 13'b0000000001000};
  localparam logic [19:0] E_JAL      = {3'b000, 2'b10, 2'b00, 13'b0000000111000};
  localparam logic [19:0] E_JR       = {3'b000, 2'b11, 2'b00, 13'b0000000001000};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; opcode = 6'd63; func = 6'd0;
    #3;
    compared++;
    if (obs !== E_ZERO) begin
      mismatched++;
      $display("FAIL reset_async: got %b expected %b", obs, E_ZERO);
    end
    tick; tick;
    compared++;
    if (obs !== E_ZERO) begin
      mismatched++;
      $display("FAIL reset_held: got %b expected %b", obs, E_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (obs !== E_FETCH) begin
      mismatched++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, E_FETCH);
    end
  endtask

  task automatic test_lw_sw;
    logic [19:0] exp [$];
    opcode = 6'd35; func = 6'd0;
    exp = {E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL lw cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
    opcode = 6'd43;
    exp = {E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL sw cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
  endtask

  task automatic test_rtype;
    logic [5:0]  fn  [4];
    logic [19:0] rex [4];
    logic [19:0] exp [$];
    fn  = '{6'd32, 6'd42, 6'd34, 6'd37};
    rex = '{E_REX_ADD, E_REX_SLT, E_REX_SUB, E_REX_OR};
    for (int k = 0; k < 4; k++) begin
      opcode = 6'd0; func = fn[k];
      exp = {E_FETCH, E_DECODE, rex[k], E_RWB, E_FETCH};
      for (int c = 0; c < exp.size(); c++) begin
        if (c > 0) tick;
        compared++;
        if (obs !== exp[c]) begin
          mismatched++;
          $display("FAIL rtype func %0d cycle %0d: got %b expected %b", fn[k], c + 1, obs, exp[c]);
        end
      end
    end
  endtask

  task automatic test_itype;
    logic [5:0]  op  [2];
    logic [19:0] iex [2];
    logic [19:0] exp [$];
    op  = '{6'd8, 6'd10};
    iex = '{E_IEX_ADD, E_IEX_SLT};
    for (int k = 0; k < 2; k++) begin
      opcode = op[k]; func = 6'd42;
      exp = {E_FETCH, E_DECODE, iex[k], E_IWB, E_FETCH};
      for (int c = 0; c < exp.size(); c++) begin
        if (c > 0) tick;
        compared++;
        if (obs !== exp[c]) begin
          mismatched++;
          $display("FAIL itype op %0d cycle %0d: got %b expected %b", op[k], c + 1, obs, exp[c]);
        end
      end
    end
  endtask

  task automatic test_branch_jump;
    logic [5:0]  op  [3];
    logic [19:0] ex3 [3];
    logic [19:0] exp [$];
    op  = '{6'd4, 6'd5, 6'd2};
    ex3 = '{E_BEQ, E_BNE, E_JUMP};
    for (int k = 0; k < 3; k++) begin
      opcode = op[k]; func = 6'd0;
      exp = {E_FETCH, E_DECODE, ex3[k], E_FETCH};
      for (int c = 0; c < exp.size(); c++) begin
        if (c > 0) tick;
        compared++;
        if (obs !== exp[c]) begin
          mismatched++;
          $display("FAIL branch_jump op %0d cycle %0d: got %b expected %b", op[k], c + 1, obs, exp[c]);
        end
      end
    end
  endtask

  task automatic test_jal_jr;
    logic [19:0] exp [$];
    opcode = 6'd3; func = 6'd0;
`ifdef MC_JAL_JR_EN
    exp = {E_FETCH, E_DECODE, E_JAL, E_FETCH};
`else
    exp = {E_FETCH, E_DEC_ILL, E_FETCH, E_DEC_ILL};
`endif
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL jal cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
`ifndef MC_JAL_JR_EN
    tick;
`endif
    opcode = 6'd0; func = 6'd8;
`ifdef MC_JAL_JR_EN
    exp = {E_FETCH, E_DECODE, E_JR, E_FETCH};
`else
    exp = {E_FETCH, E_DECODE, E_REX_ILL, E_FETCH};
`endif
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL jr cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [19:0] exp [$];
    opcode = 6'd63; func = 6'd0;
    exp = {E_FETCH, E_DEC_ILL, E_FETCH};
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL illegal_op cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
    opcode = 6'd0; func = 6'd9;
    exp = {E_FETCH, E_DECODE, E_REX_ILL, E_FETCH};
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL illegal_func cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [19:0] exp [$];
    opcode = 6'd35; func = 6'd0;
    exp = {E_FETCH, E_DECODE, E_MEMADR, E_MEMRD};
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL rstmid lw cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    compared++;
    if (obs !== E_ZERO) begin
      mismatched++;
      $display("FAIL rstmid_abort: got %b expected %b", obs, E_ZERO);
    end
    tick;
    compared++;
    if (obs !== E_ZERO) begin
      mismatched++;
      $display("FAIL rstmid_held: got %b expected %b", obs, E_ZERO);
    end
    #2;
    rst = 1'b0; opcode = 6'd2;
    #1;
    exp = {E_FETCH, E_DECODE, E_JUMP, E_FETCH};
    for (int c = 0; c < exp.size(); c++) begin
      if (c > 0) tick;
      compared++;
      if (obs !== exp[c]) begin
        mismatched++;
        $display("FAIL rstmid_after cycle %0d: got %b expected %b", c + 1, obs, exp[c]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw_sw;
    test_rtype;
    test_itype;
    test_branch_jump;
    test_jal_jr;
    test_illegal;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: opcode  input  6  instruction bits 31:26 from the datapath IR.
REQ-004 SHALL: func  input  6  instruction bits 5:0 from the datapath IR.
REQ-005 SHALL: AluOperation  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-006 SHALL: PCSrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
REQ-007 SHALL: AluSrcB  output  2  ALU B operand: 00 B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-008 SHALL: single-bit outputs AluSrcA, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, link, PCWrite, PCWriteCond, branch; each drives the same-named datapath control.
REQ-009 SHALL: illegal  output  1  one-cycle pulse on an unsupported instruction.

Function
REQ-010 SHALL: implement a Moore FSM; outputs decode from the current state, plus opcode for branch and func for AluOperation.
REQ-011 SHALL: every output not listed for a state is 0 in that state.
REQ-012 SHALL: FETCH: MemRead=1, IRWrite=1, IorD=0, AluSrcA=0, AluSrcB=01, ADD, PCSrc=00, PCWrite=1; next state is DECODE.
REQ-013 SHALL: DECODE: AluSrcA=0, AluSrcB=11, ADD (branch target into ALUOut); dispatch on opcode per REQ-014.
REQ-014 SHALL: dispatch: 35 (lw) or 43 (sw) to MEMADR; 0 to REXEC, or to JR if func=8; 8 (addi) or 10 (slti) to IEXEC; 4 (beq) or 5 (bne) to BRANCH; 2 to JUMP; 3 to JAL; anything else to FETCH with illegal=1 in DECODE.
REQ-015 SHALL: MEMADR: AluSrcA=1, AluSrcB=10, ADD; next state is MEMRD for lw, MEMWR for sw.
REQ-016 SHALL: MEMRD: IorD=1, MemRead=1; next state is MEMWB. MEMWB: MemToReg=1, RegDst=0, RegWrite=1; next state is FETCH.
REQ-017 SHALL: MEMWR: IorD=1, MemWrite=1; next state is FETCH.
REQ-018 SHALL: REXEC: AluSrcA=1, AluSrcB=00; AluOperation from func: 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT.
REQ-019 SHALL: an R-type func outside {32, 34, 36, 37, 42, 8} is illegal: pulse illegal in REXEC, go to FETCH, no RegWrite.
REQ-020 SHALL: REXEC leads to RWB. RWB: RegDst=1, MemToReg=0, RegWrite=1; next state is FETCH.
REQ-021 SHALL: IEXEC: AluSrcA=1, AluSrcB=10; ADD for addi, SLT for slti; next state is IWB. IWB: RegDst=0, MemToReg=0, RegWrite=1; next state is FETCH.
REQ-022 SHALL: BRANCH: AluSrcA=1, AluSrcB=00, SUB, PCSrc=01, PCWriteCond=1; branch=1 for beq, 0 for bne; next state is FETCH.
REQ-023 SHALL: JUMP: PCSrc=10, PCWrite=1; next state is FETCH.
REQ-024 SHALL: JAL: PCSrc=10, PCWrite=1, link=1, RegWrite=1; this writes PC+4 to r31; next state is FETCH.
REQ-025 SHALL: JR: PCSrc=11, PCWrite=1; next state is FETCH.
REQ-026 SHALL: PCWrite and PCWriteCond are never both 1; MemRead and MemWrite are never both 1.
REQ-027 SHALL: cycles per instruction: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3; illegal 2 (illegal R-type 3).

Reset
REQ-028 SHALL: while rst=1, state is FETCH and every output is forced to 0, regardless of clk.
REQ-029 SHALL: reset asserted mid-instruction aborts it immediately with no further writes.
REQ-030 SHALL: the first rising edge after rst deasserts executes FETCH outputs.

Configuration
REQ-031 SHALL: the macro MC_JAL_JR_EN controls jal/jr support.
REQ-032 SHALL: with MC_JAL_JR_EN defined, JAL and JR behave as in REQ-024 and REQ-025.
REQ-033 SHALL: without MC_JAL_JR_EN, JAL and JR states are absent; opcode 3 and R-type func 8 are illegal (per REQ-014/REQ-019) and link is tied to 0.

Verification
REQ-034 SHALL: cover lw (opcode 35): states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH; RegWrite=1 only in cycle 5 with MemToReg=1.
REQ-035 SHALL: cover add (opcode 0, func 32): AluOperation=010 in cycle 3 and RegWrite=1, RegDst=1 in cycle 4. Repeat with func 42: AluOperation=111.
REQ-036 SHALL: cover beq then bne: cycle 3 has PCWriteCond=1, PCSrc=01, AluOperation=110, with branch=1 for beq and branch=0 for bne; next instruction fetches at cycle 4.
REQ-037 SHALL: cover jal with MC_JAL_JR_EN defined: cycle 3 has link=1, RegWrite=1, PCWrite=1, PCSrc=10. Rebuilt without the macro: illegal=1 in cycle 2, FETCH in cycle 3, RegWrite never 1.
REQ-038 SHALL: cover opcode 63: illegal pulses exactly once in DECODE, then FETCH, with no MemWrite, RegWrite or PCWrite after FETCH.
REQ-039 SHALL: cover rst asserted during MEMRD of lw: all outputs 0 in the same cycle; after release, FETCH outputs appear and MemToReg/RegWrite never assert for the aborted lw.
